// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane masks
// and the word-crossing predicate used by both the control and alignment logic.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = MASK_BYTE;
            SZ_HALF: m = MASK_HALF;
            SZ_WORD: m = MASK_WORD;
            default: m = MASK_NONE;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // True when the access spills past the last byte lane of its word.
    function automatic logic access_crosses(input logic [1:0] off, input logic [1:0] size);
        return (({1'b0, off} + size_nbytes(size)) > 3'd4);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store rotation, two-word write mask and
// load extraction with zero/sign extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [23:0] word1,
    output logic [31:0] wdata_rot,
    output logic [3:0]  wren_lo,
    output logic [3:0]  wren_hi,
    output logic [31:0] ld_ext
);

    logic [7:0]  m8_s;
    logic [31:0] raw_s;

    // Rotate store data onto lanes and build the mask across both words.
    always_comb begin
        m8_s = {4'b0000, size_mask(size)} << off;
        wren_lo = m8_s[3:0];
        wren_hi = m8_s[7:4];
        case (off)
            2'd0:    wdata_rot = wdata;
            2'd1:    wdata_rot = {wdata[23:0], wdata[31:24]};
            2'd2:    wdata_rot = {wdata[15:0], wdata[31:16]};
            2'd3:    wdata_rot = {wdata[7:0],  wdata[31:8]};
            default: wdata_rot = 32'h0000_0000;
        endcase
    end

    // Bytes from the second word only ever fill the upper lanes of the result.
    always_comb begin
        case (off)
            2'd0:    raw_s = word0;
            2'd1:    raw_s = {word1[7:0],  word0[31:8]};
            2'd2:    raw_s = {word1[15:0], word0[31:16]};
            2'd3:    raw_s = {word1[23:0], word0[31:24]};
            default: raw_s = 32'h0000_0000;
        endcase
        case (size)
            SZ_BYTE: ld_ext = {{24{sign_ext & raw_s[7]}},  raw_s[7:0]};
            SZ_HALF: ld_ext = {{16{sign_ext & raw_s[15]}}, raw_s[15:0]};
            SZ_WORD: ld_ext = raw_s;
            default: ld_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one access at a time onto a word-addressed byte-lane memory.
// Define LSU_MISALIGN_EN to split word-crossing accesses into two cycles.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] ld_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wren,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_r, state_next_s;
    logic        we_r, sx_r, err_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r, wdata_r, word0_r, ld_data_r;
    logic        accept_s, reject_s, ld_cap_s, w0_cap_s, req_bad_s;
    logic [31:0] wdata_rot_s, ld_ext_s, word0_s;
    logic [3:0]  wren_lo_s, wren_hi_s;

`ifdef LSU_MISALIGN_EN
    assign req_bad_s = (size == SZ_RSVD);
`else
    assign req_bad_s = (size == SZ_RSVD) || access_crosses(addr[1:0], size);
`endif

    // In the second cycle the first word comes from the capture register.
    assign word0_s = (state_r == ST_ACC1) ? word0_r : mem_rdata;

    lsu_align u_align (
        .off       (addr_r[1:0]),
        .size      (size_r),
        .sign_ext  (sx_r),
        .wdata     (wdata_r),
        .word0     (word0_s),
        .word1     (mem_rdata[23:0]),
        .wdata_rot (wdata_rot_s),
        .wren_lo   (wren_lo_s),
        .wren_hi   (wren_hi_s),
        .ld_ext    (ld_ext_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and capture strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        ld_cap_s     = 1'b0;
        w0_cap_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    accept_s = 1'b1;
                    if (req_bad_s) begin
                        reject_s     = 1'b1;
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ACC0;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACC0: begin
                w0_cap_s = 1'b1;
`ifdef LSU_MISALIGN_EN
                if (access_crosses(addr_r[1:0], size_r)) begin
                    state_next_s = ST_ACC1;
                end else begin
                    ld_cap_s     = ~we_r;
                    state_next_s = ST_DONE;
                end
`else
                ld_cap_s     = ~we_r;
                state_next_s = ST_DONE;
`endif
            end
            ST_ACC1: begin
`ifdef LSU_MISALIGN_EN
                ld_cap_s     = ~we_r;
                state_next_s = ST_DONE;
`else
                state_next_s = ST_IDLE;
`endif
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Request latch, first-word capture and load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r      <= 1'b0;
            sx_r      <= 1'b0;
            size_r    <= 2'b00;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            err_r     <= 1'b0;
            word0_r   <= 32'h0000_0000;
            ld_data_r <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                we_r    <= we;
                sx_r    <= sign_ext;
                size_r  <= size;
                addr_r  <= addr;
                wdata_r <= wdata;
                err_r   <= reject_s;
            end
            if (w0_cap_s) begin
                word0_r <= mem_rdata;
            end
            if (ld_cap_s) begin
                ld_data_r <= ld_ext_s;
            end
        end
    end

    // Write enables exist only while an access cycle is in flight.
    always_comb begin
        case (state_r)
            ST_ACC0: mem_wren = we_r ? wren_lo_s : 4'b0000;
            ST_ACC1: mem_wren = we_r ? wren_hi_s : 4'b0000;
            default: mem_wren = 4'b0000;
        endcase
    end

    assign mem_addr  = {addr_r[31:2], 2'b00} + ((state_r == ST_ACC1) ? 32'd4 : 32'd0);
    assign mem_wdata = wdata_rot_s;
    assign ready     = (state_r == ST_IDLE);
    assign done      = (state_r == ST_DONE);
    assign err       = err_r;
    assign ld_data   = ld_data_r;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-lane memory model, reference byte image and
// a scoreboard of expected completion results.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        ready, done, err;
    logic [31:0] ld_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wren;

    lsu dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
        .ld_data(ld_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

`ifdef LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct { logic err; logic [31:0] ld; } exp_t;
    exp_t sb_q[$];

    logic [31:0] mem [0:1023];
    logic [7:0]  ref_mem [0:4095];
    int          n_tests = 0, n_fail = 0, cyc = 0;
    logic [31:0] last_ld = 32'h0;
    logic [31:0] last_wd1 = 32'h0;
    int          last_lat = 0, accept_cyc = 0;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int l = 0; l < 4; l++)
            if (mem_wren[l]) mem[mem_addr[11:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
    end

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
        logic [31:0] r = 32'h0;
        logic [31:0] ai;
        int nb = nbytes_of(sz);
        for (int i = 0; i < nb; i++) begin
            ai = a + i;
            r[8*i +: 8] = ref_mem[ai[11:0]];
        end
        for (int j = nb; j < 4; j++)
            r[8*j +: 8] = (sx && r[8*nb-1]) ? 8'hFF : 8'h00;
        return r;
    endfunction

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d, input string name);
        int          nb = nbytes_of(sz);
        int          off = int'(a[1:0]);
        logic        crosses = (off + nb) > 4;
        logic        bad = (sz == 2'b11) || (crosses && !MIS);
        int          exp_lat = bad ? 1 : (crosses ? 3 : 2);
        logic [7:0]  m8 = 8'h00;
        logic [3:0]  wr [1:8];
        logic [31:0] ad [1:8];
        logic [31:0] wd1 = 32'h0;
        logic [31:0] ai;
        int          lat = 0, t = 0;
        exp_t        e, got;
        for (int i = 0; i < nb; i++) m8[off + i] = 1'b1;
        e.err = bad;
        e.ld  = (bad || w) ? last_ld : model_load(a, sz, sx);
        sb_q.push_back(e);
        while (!ready && t < 20) begin @(negedge clk); t++; end
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL %s ready: got %b want 1", name, ready); end
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        @(posedge clk); accept_cyc = cyc; #1 req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            wr[k] = mem_wren; ad[k] = mem_addr;
            if (k == 1) wd1 = mem_wdata;
            if (done === 1'b1) begin lat = k; break; end
        end
        last_wd1 = wd1;
        n_tests++;
        if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
        if (lat >= 1) begin
            n_tests++;
            if (wr[lat] !== 4'b0000) begin n_fail++; $display("FAIL %s wren_in_done: got %b want 0000", name, wr[lat]); end
        end
        if (lat >= 2) begin
            n_tests++;
            if (wr[1] !== (w ? m8[3:0] : 4'b0000) || ad[1] !== {a[31:2], 2'b00}) begin
                n_fail++; $display("FAIL %s acc0: wren %b addr %h want %b %h", name, wr[1], ad[1], (w ? m8[3:0] : 4'b0000), {a[31:2], 2'b00});
            end
        end
        if (lat >= 3) begin
            n_tests++;
            if (wr[2] !== (w ? m8[7:4] : 4'b0000) || ad[2] !== ({a[31:2], 2'b00} + 32'd4)) begin
                n_fail++; $display("FAIL %s acc1: wren %b addr %h want %b %h", name, wr[2], ad[2], (w ? m8[7:4] : 4'b0000), {a[31:2], 2'b00} + 32'd4);
            end
        end
        got = sb_q.pop_front();
        n_tests++;
        if (err !== got.err || ld_data !== got.ld) begin
            n_fail++; $display("FAIL %s result: err %b ld %h want %b %h", name, err, ld_data, got.err, got.ld);
        end
        last_ld = got.ld;
        last_lat = lat;
        if (!bad && w)
            for (int i = 0; i < nb; i++) begin
                ai = a + i;
                ref_mem[ai[11:0]] = d[8*i +: 8];
            end
    endtask

    task automatic check_word(input logic [31:0] a, input string name);
        logic [31:0] exp_w;
        for (int i = 0; i < 4; i++) exp_w[8*i +: 8] = ref_mem[{a[11:2], 2'b00} + 12'(i)];
        n_tests++;
        if (mem[a[11:2]] !== exp_w) begin n_fail++; $display("FAIL %s mem: got %h want %h", name, mem[a[11:2]], exp_w); end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'(i) * 32'h9E37_79B1;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = mem[i][8*b +: 8];
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({ready, done, err, mem_wren} !== 7'b100_0000 || ld_data !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_state: rdy %b done %b err %b wren %b ld %h ma %h wd %h", ready, done, err, mem_wren, ld_data, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL reset_release: rdy %b done %b want 1 0", ready, done); end
    endtask

    task automatic test_word();
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, "sw_100");
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, "lw_100");
        n_tests++;
        if (ld_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_const: got %h want deadbeef", ld_data); end
        check_word(32'h100, "sw_100");
    endtask

    task automatic test_byte();
        do_req(1'b1, 2'b00, 1'b0, 32'h203, 32'h0000_0080, "sb_203");
        n_tests++;
        if (last_wd1[31:24] !== 8'h80) begin n_fail++; $display("FAIL sb_lane: got %h want 80", last_wd1[31:24]); end
        do_req(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, "lb_203");
        n_tests++;
        if (ld_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_const: got %h want ffffff80", ld_data); end
        do_req(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, "lbu_203");
        n_tests++;
        if (ld_data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_const: got %h want 00000080", ld_data); end
        check_word(32'h200, "sb_203");
    endtask

    task automatic test_half();
        do_req(1'b1, 2'b01, 1'b0, 32'h302, 32'hABCD_1234, "sh_302");
        do_req(1'b0, 2'b01, 1'b0, 32'h302, 32'h0, "lhu_302");
        n_tests++;
        if (ld_data !== 32'h0000_1234) begin n_fail++; $display("FAIL lhu_const: got %h want 00001234", ld_data); end
        check_word(32'h300, "sh_302");
    endtask

    task automatic test_misalign();
        do_req(1'b1, 2'b10, 1'b0, 32'h401, 32'h1122_3344, "sw_401");
        do_req(1'b0, 2'b10, 1'b0, 32'h401, 32'h0, "lw_401");
        check_word(32'h400, "sw_401_w0");
        check_word(32'h404, "sw_401_w1");
        do_req(1'b1, 2'b01, 1'b0, 32'h40B, 32'h0000_F00D, "sh_40b");
        do_req(1'b0, 2'b01, 1'b1, 32'h40B, 32'h0, "lh_40b");
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, "lw_wrap");
    endtask

    task automatic test_reserved();
        do_req(1'b1, 2'b11, 1'b0, 32'h500, 32'h5555_AAAA, "rsvd_st");
        do_req(1'b0, 2'b11, 1'b1, 32'h504, 32'h0, "rsvd_ld");
        check_word(32'h500, "rsvd_st");
    endtask

    task automatic test_reset_mid();
        int t = 0;
        while (!ready && t < 20) begin @(negedge clk); t++; end
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h508; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1 req = 1'b0;
        n_tests++;
        if (mem_wren !== 4'b1111) begin n_fail++; $display("FAIL mid_acc0_wren: got %b want 1111", mem_wren); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_wren !== 4'b0000 || ready !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: wren %b rdy %b done %b want 0000 1 0", mem_wren, ready, done);
        end
        @(negedge clk); rst_n = 1'b1;
        last_ld = 32'h0;
        check_word(32'h508, "mid_reset_nowrite");
        do_req(1'b1, 2'b10, 1'b0, 32'h508, 32'h0BAD_CAFE, "post_rst_sw");
        do_req(1'b0, 2'b10, 1'b0, 32'h508, 32'h0, "post_rst_lw");
    endtask

    task automatic test_back_to_back();
        int prev_acc, prev_lat;
        logic [1:0] sz;
        do_req(1'b0, 2'b00, 1'b0, 32'h600, 32'h0, "b2b_first");
        for (int n = 0; n < 24; n++) begin
            prev_acc = accept_cyc; prev_lat = last_lat;
            sz = 2'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   32'h600 + 32'($urandom_range(0, 31)), $urandom, "b2b");
            n_tests++;
            if (accept_cyc - prev_acc != prev_lat + 1) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", accept_cyc - prev_acc, prev_lat + 1);
            end
        end
        for (int a = 0; a < 40; a += 4) check_word(32'h600 + 32'(a), "b2b_mem");
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_reserved();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator side of the data memory port. It accepts one load or store request at a time from the CPU datapath and drives the word-addressed, byte-lane data memory (combinational read, byte-lane write enables committed on the clock edge). It rotates and masks store data onto byte lanes and extracts/extends load data. Accesses that cross a word boundary are optionally split into two memory cycles.

## Interface
- No parameters; data/address width fixed at 32.
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  1  request valid; accepted only when `ready`=1
- `we`  in  1  1 = store, 0 = load
- `size`  in  2  00 byte, 01 half, 10 word, 11 reserved
- `sign_ext`  in  1  loads only: 1 sign-extend, 0 zero-extend
- `addr`  in  32  byte address
- `wdata`  in  32  store data, right-justified
- `ready`  out  1  1 in IDLE only
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`; 1 = request rejected, no memory effect
- `ld_data`  out  32  load result, valid with `done`, held until next `done`
- `mem_addr`  out  32  word-aligned address to memory (bits [1:0]=0)
- `mem_wdata`  out  32  lane-rotated store data
- `mem_wren`  out  4  per-byte-lane write enables
- `mem_rdata`  in  32  combinational read data from memory

## Operation
- States: IDLE, ACC0, ACC1, DONE.
- IDLE: `ready`=1. On `req`: latch we/size/sign_ext/addr/wdata. size=11 (or misaligned with macro off) → DONE with err=1; else → ACC0.
- off = addr[1:0]; nbytes = 1/2/4; mask = 0001/0011/1111; m8 = {4'b0,mask} << off; crosses = (off+nbytes > 4).
- ACC0: mem_addr = {addr[31:2],2'b00}; mem_wdata = wdata rotated left by 8*off; mem_wren = we ? m8[3:0] : 0. Load: capture mem_rdata as word0. → ACC1 if crosses, else DONE.
- ACC1: mem_addr = first address + 4 (wraps mod 2^32); same mem_wdata; mem_wren = we ? m8[7:4] : 0. Load: capture word1. → DONE.
- Load result byte i (i < nbytes) = lane (off+i) mod 4 of word0 if off+i<4, else of word1; upper bytes zero- or sign-extended from bit 8*nbytes-1. Stores set ld_data unchanged.
- DONE: `done`=1 for one cycle, err valid; → IDLE. `req` in DONE or any non-IDLE state is ignored (no queue).
- mem_wren = 0 in IDLE and DONE.

## Timing
- Reset: state IDLE, ready=1, done=0, err=0, ld_data=0, latched addr=0 (mem_addr=0), mem_wren=0, mem_wdata=0.
- Request accepted at edge T0; ACC0 during cycle after T0; store commits / load word captured at T1.
- Single word: done high in cycle after T1 (2 cycles after acceptance). Split: done one cycle later (3). Error: done in cycle after T0.
- Next request accepted earliest at edge ending DONE+IDLE cycle; throughput one access per 3 (4 split) cycles.
- Reset mid-operation: immediate return to IDLE, mem_wren deasserts asynchronously; a split store may leave the first word written — caller's responsibility.

## Configuration
- `LSU_MISALIGN_EN` defined: crossing accesses split via ACC1 as above.
- Undefined: ACC1 removed; any access with crosses=1 (half at off=3, word at off≠0) completes with err=1, no write, ld_data unchanged. Aligned behaviour identical.

## Structure
- `lsu_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, byte-mask constants.
- Sub-module `lsu_align`: purely combinational lane rotate, write-mask generation and load extract/extend; FSM and registers stay in `lsu`.

## Test plan
- Store word 0xDEADBEEF at 0x100, load word 0x100 → mem_wren=1111 at 0x100; ld_data=0xDEADBEEF, err=0, done 2 cycles after accept.
- Store byte 0x80 at 0x203, load byte signed/unsigned at 0x203 → mem_wren=1000, mem_wdata[31:24]=0x80; ld_data=0xFFFFFF80 / 0x00000080.
- Half store 0x1234 at 0x302 then lhu → wren=1100; ld_data=0x00001234; other lanes of 0x300 unchanged.
- Macro on: word store 0x11223344 at 0x401 → ACC0 wren=1110 at 0x400, ACC1 wren=0001 at 0x404; load back 0x11223344, done 3 cycles after accept. Macro off: err=1, no wren.
- size=11 request → done next cycle, err=1, mem_wren never asserted.
- Assert rst_n low during ACC0 of a store → mem_wren=0 immediately, ready=1, done=0; next request proceeds normally.
